// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU memory-side blocks: default bus widths and
// the arbiter FSM state encoding.
package gpu_mem_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } arb_state_t;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Rotating-priority search: returns the first set request at or after ptr,
// wrapping from the top index back to 0.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic                found,
  output logic [IDX_BITS-1:0] index
);

  int cand;

  // Walk from the farthest offset down so the nearest request wins last.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (req[cand]) begin
        found = 1'b1;
        index = IDX_BITS'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory read/write channel among several
// consumers, one transaction at a time.
module mem_rr_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
  output logic                                      mem_read_valid,
  output logic [ADDR_BITS-1:0]                      mem_read_address,
  input  logic                                      mem_read_ready,
  input  logic [DATA_BITS-1:0]                      mem_read_data,
  output logic                                      mem_write_valid,
  output logic [ADDR_BITS-1:0]                      mem_write_address,
  output logic [DATA_BITS-1:0]                      mem_write_data,
  input  logic                                      mem_write_ready,
  output logic                                      busy,
  output logic [$clog2(NUM_CONSUMERS)-1:0]          grant_id
);

  localparam int IDX_BITS = $clog2(NUM_CONSUMERS);

  arb_state_t                              state, state_n;
  logic [IDX_BITS-1:0]                     rr_ptr, rr_ptr_n, grant_id_n;
  logic                                    busy_n;
  logic                                    mem_read_valid_n, mem_write_valid_n;
  logic [ADDR_BITS-1:0]                    mem_read_address_n, mem_write_address_n;
  logic [DATA_BITS-1:0]                    mem_write_data_n;
  logic [NUM_CONSUMERS-1:0]                read_ready_n, write_ready_n;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_n;

  logic [NUM_CONSUMERS-1:0] any_req;
  logic                     pick_found;
  logic [IDX_BITS-1:0]      pick_idx;

  assign any_req = consumer_read_valid | consumer_write_valid;

  rr_pick #(
    .NUM_REQ  (NUM_CONSUMERS),
    .IDX_BITS (IDX_BITS)
  ) u_pick (
    .req   (any_req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant_id             <= '0;
      busy                 <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      state                <= state_n;
      rr_ptr               <= rr_ptr_n;
      grant_id             <= grant_id_n;
      busy                 <= busy_n;
      mem_read_valid       <= mem_read_valid_n;
      mem_read_address     <= mem_read_address_n;
      mem_write_valid      <= mem_write_valid_n;
      mem_write_address    <= mem_write_address_n;
      mem_write_data       <= mem_write_data_n;
      consumer_read_ready  <= read_ready_n;
      consumer_write_ready <= write_ready_n;
      consumer_read_data   <= read_data_n;
    end
  end

  // Everything holds unless the current state explicitly moves it, which also
  // keeps the memory address/data stable for the whole WAIT phase.
  always_comb begin
    state_n             = state;
    rr_ptr_n            = rr_ptr;
    grant_id_n          = grant_id;
    busy_n              = busy;
    mem_read_valid_n    = mem_read_valid;
    mem_read_address_n  = mem_read_address;
    mem_write_valid_n   = mem_write_valid;
    mem_write_address_n = mem_write_address;
    mem_write_data_n    = mem_write_data;
    read_ready_n        = consumer_read_ready;
    write_ready_n       = consumer_write_ready;
    read_data_n         = consumer_read_data;

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_id_n = pick_idx;
          rr_ptr_n   = (pick_idx == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0
                                                                  : pick_idx + IDX_BITS'(1);
          busy_n     = 1'b1;
          // A consumer asking for both is served its read first.
          if (consumer_read_valid[pick_idx]) begin
            mem_read_valid_n   = 1'b1;
            mem_read_address_n = consumer_read_address[pick_idx];
            state_n            = READ_WAIT;
          end else begin
            mem_write_valid_n   = 1'b1;
            mem_write_address_n = consumer_write_address[pick_idx];
            mem_write_data_n    = consumer_write_data[pick_idx];
            state_n             = WRITE_WAIT;
          end
        end
      end

      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_n      = 1'b0;
          read_data_n[grant_id] = mem_read_data;
          read_ready_n[grant_id] = 1'b1;
          state_n               = READ_RELAY;
        end
      end

      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_n       = 1'b0;
          write_ready_n[grant_id] = 1'b1;
          state_n                 = WRITE_RELAY;
        end
      end

      READ_RELAY: begin
        if (!consumer_read_valid[grant_id]) begin
          read_ready_n = '0;
          busy_n       = 1'b0;
          state_n      = IDLE;
        end
      end

      WRITE_RELAY: begin
        if (!consumer_write_valid[grant_id]) begin
          write_ready_n = '0;
          busy_n        = 1'b0;
          state_n       = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
